// File: rtl/uart_rx_core_if.sv
// Byte handshake between uart_rx_core (master) and its consumer (slave).
interface uart_rx_core_if;
    logic [7:0] rxdata;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rxdata, output rx_valid, input rx_ready);
    modport slave  (input rxdata, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver with one-entry holding register, rts flow control and error pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames (extra even-parity bit before the stop bit).
module uart_rx_core #(
    parameter int BIT_CLK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    uart_rx_core_if.master        bus,
    output logic                  rts,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CW = $clog2(BIT_CLK);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] HALF_M1  = CW'(BIT_CLK / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(BIT_CLK - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd5,
`endif
        WAIT_IDLE = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    logic          sync1_r;
    logic          rxs_r;
    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    bit_r, bit_s;
    logic [7:0]    shift_r, shift_s;
    logic          good_s;
    logic          ferr_s;
`ifdef UART_RX_PARITY_EN
    logic          par_err_r, par_err_s;
`endif

    logic [7:0]    rxdata_r;
    logic          rx_valid_r;
    logic          rts_r;
    logic          frame_err_r;
    logic          overrun_r;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= rxd;
            rxs_r   <= sync1_r;
        end
    end

    // Frame FSM state, bit timing and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            bit_r     <= 3'd0;
            shift_r   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_err_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_r     <= bit_s;
            shift_r   <= shift_s;
`ifdef UART_RX_PARITY_EN
            par_err_r <= par_err_s;
`endif
        end
    end

    // Next-state logic; the counter free-runs and is cleared at every sample point.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + CNT_ONE;
        bit_s   = bit_r;
        shift_s = shift_r;
        good_s  = 1'b0;
        ferr_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_s = par_err_r;
`endif
        case (state_r)
            IDLE: begin
                cnt_s = CNT_ZERO;
`ifdef UART_RX_PARITY_EN
                par_err_s = 1'b0;
`endif
                if (rxs_r == 1'b0) state_s = START;
                else               state_s = IDLE;
            end
            START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_s = CNT_ZERO;
                    bit_s = 3'd0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (rxs_r == 1'b1) state_s = IDLE;
                    else               state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s   = CNT_ZERO;
                    shift_s = {rxs_r, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_s = AFTER_DATA;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s     = CNT_ZERO;
                    par_err_s = (rxs_r != even_par(shift_r));
                    ferr_s    = par_err_s;
                    state_s   = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s = CNT_ZERO;
                    if (rxs_r == 1'b1) begin
`ifdef UART_RX_PARITY_EN
                        good_s = !par_err_r;
`else
                        good_s = 1'b1;
`endif
                        state_s = IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = WAIT_IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            WAIT_IDLE: begin
                cnt_s = CNT_ZERO;
                // A held-low line (break) must return high before a new start is accepted.
                if (rxs_r == 1'b1) state_s = IDLE;
                else               state_s = WAIT_IDLE;
            end
            default: begin
                cnt_s   = CNT_ZERO;
                state_s = IDLE;
            end
        endcase
    end

    // Holding register, handshake, flow control and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxdata_r    <= 8'h00;
            rx_valid_r  <= 1'b0;
            rts_r       <= 1'b1;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            rts_r       <= !rx_valid_r;
            frame_err_r <= ferr_s;
            overrun_r   <= good_s && rx_valid_r && !bus.rx_ready;
            if (good_s && (!rx_valid_r || bus.rx_ready)) begin
                rxdata_r   <= shift_r;
                rx_valid_r <= 1'b1;
            end else if (rx_valid_r && bus.rx_ready) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    assign bus.rxdata   = rxdata_r;
    assign bus.rx_valid = rx_valid_r;
    assign rts          = rts_r;
    assign frame_err    = frame_err_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame-level reference model (scheduled completion events plus a
// holding-register model) compared every cycle, directed scenarios and random traffic.
module tb_uart_rx_core;

    localparam int BIT  = 8;
    localparam int HALF = BIT / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic rxd   = 1'b1;
    logic rts, frame_err, overrun;

    uart_rx_core_if bus ();

    uart_rx_core #(.BIT_CLK(BIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .bus       (bus),
        .rts       (rts),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         good;
        logic [7:0] data;
    } ev_t;

    ev_t  evq[$];
    logic [7:0] dlv[$];
    int   cyc_r    = 0;
    int   ferr_cnt = 0;
    int   ovr_cnt  = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    bit   rnd_rdy  = 1'b0;

    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_rts   = 1'b1;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_r, act, exp);
        end
    endtask

    always @(posedge clk) cyc_r <= cyc_r + 1;

    // Reference model: a frame completes at its scheduled edge, then the one-entry buffer rules apply.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_rts   <= 1'b1;
            m_ferr  <= 1'b0;
            m_ovr   <= 1'b0;
            evq.delete();
        end else begin
            m_rts  <= !m_valid;
            m_ferr <= 1'b0;
            m_ovr  <= 1'b0;
            if (evq.size() > 0 && evq[0].due == cyc_r + 1) begin
                if (evq[0].good) begin
                    if (!m_valid || bus.rx_ready) begin
                        m_data  <= evq[0].data;
                        m_valid <= 1'b1;
                    end else begin
                        m_ovr <= 1'b1;
                    end
                end else begin
                    m_ferr <= 1'b1;
                    if (m_valid && bus.rx_ready) m_valid <= 1'b0;
                end
                void'(evq.pop_front());
            end else if (m_valid && bus.rx_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Observation log of what the consumer actually received and of the error pulses.
    always @(posedge clk) begin
        if (rst_n && bus.rx_valid && bus.rx_ready) dlv.push_back(bus.rxdata);
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("rx_valid",  {31'd0, bus.rx_valid}, {31'd0, m_valid});
            chk("rxdata",    {24'd0, bus.rxdata},   {24'd0, m_data});
            chk("rts",       {31'd0, rts},          {31'd0, m_rts});
            chk("frame_err", {31'd0, frame_err},    {31'd0, m_ferr});
            chk("overrun",   {31'd0, overrun},      {31'd0, m_ovr});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) bus.rx_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame and schedules its expected outcome from the frame timing rules.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        int  k;
        int  stop_due;
        ev_t e;
        k        = cyc_r;
        stop_due = k + 3 + HALF + NB * BIT;
        e.data   = b;
`ifdef UART_RX_PARITY_EN
        if (par_flip) begin
            e.due  = stop_due - BIT;
            e.good = 1'b0;
            evq.push_back(e);
        end
        if (!stop_bit || !par_flip) begin
            e.due  = stop_due;
            e.good = stop_bit;
            evq.push_back(e);
        end
`else
        e.due  = stop_due;
        e.good = stop_bit;
        if (par_flip == 1'b0) evq.push_back(e);
        else                  evq.push_back(e);
`endif
        rxd = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        tick(BIT);
`endif
        rxd = stop_bit;
        tick(BIT);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        rxd = 1'b0;
        tick(BIT);
        for (int i = 0; i < nbits; i++) begin
            rxd = b[i];
            tick(BIT);
        end
    endtask

    initial begin
        int f0;
        int o0;
        logic [7:0] rb;
        logic       rs;
        logic       rp;
        bus.rx_ready = 1'b0;
        #2 rst_n = 1'b0;
        tick(4);
        chk("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("reset_rxdata",   {24'd0, bus.rxdata},   32'd0);
        chk("reset_rts",      {31'd0, rts},          32'd1);
        rst_n = 1'b1;
        tick(2 * BIT);

        // Three bytes straight through with the consumer always ready.
        bus.rx_ready = 1'b1;
        dlv.delete();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_frame(8'h77, 1'b1, 1'b0);
        tick(BIT);
        send_frame(8'hAA, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        tick(2 * BIT);
        chk("p1_count", dlv.size(), 32'd3);
        if (dlv.size() == 3) begin
            chk("p1_byte0", {24'd0, dlv[0]}, 32'h77);
            chk("p1_byte1", {24'd0, dlv[1]}, 32'hAA);
            chk("p1_byte2", {24'd0, dlv[2]}, 32'h33);
        end
        chk("p1_errs", ferr_cnt - f0 + ovr_cnt - o0, 32'd0);
        chk("p1_rts",  {31'd0, rts}, 32'd1);

        // Overrun: second byte dropped while the first is still held.
        bus.rx_ready = 1'b0;
        dlv.delete();
        o0 = ovr_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        tick(2 * BIT);
        chk("p2_valid",   {31'd0, bus.rx_valid}, 32'd1);
        chk("p2_data",    {24'd0, bus.rxdata},   32'h55);
        chk("p2_rts",     {31'd0, rts},          32'd0);
        chk("p2_overrun", ovr_cnt - o0,          32'd1);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        tick(3);
        chk("p2_count", dlv.size(), 32'd1);
        if (dlv.size() == 1) chk("p2_byte", {24'd0, dlv[0]}, 32'h55);
        chk("p2_valid_clr", {31'd0, bus.rx_valid}, 32'd0);

        // Short low glitch on an idle line.
        bus.rx_ready = 1'b1;
        dlv.delete();
        f0 = ferr_cnt;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(12 * BIT);
        chk("p3_count", dlv.size(),     32'd0);
        chk("p3_ferr",  ferr_cnt - f0,  32'd0);

        // Framing error followed by a long break, then a clean byte.
        dlv.delete();
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0, 1'b0);
        rxd = 1'b0;
        tick(19 * BIT);
        rxd = 1'b1;
        tick(2 * BIT);
        send_frame(8'h3C, 1'b1, 1'b0);
        tick(2 * BIT);
        chk("p4_ferr",  ferr_cnt - f0, 32'd1);
        chk("p4_count", dlv.size(),    32'd1);
        if (dlv.size() == 1) chk("p4_byte", {24'd0, dlv[0]}, 32'h3C);

        // Reset in the middle of a frame.
        bus.rx_ready = 1'b0;
        send_frame(8'h9E, 1'b1, 1'b0);
        tick(BIT);
        send_partial(8'hFF, 3);
        rxd   = 1'b1;
        rst_n = 1'b0;
        tick(3);
        chk("p5_rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("p5_rst_data",  {24'd0, bus.rxdata},   32'd0);
        chk("p5_rst_rts",   {31'd0, rts},          32'd1);
        chk("p5_rst_pulse", {30'd0, frame_err, overrun}, 32'd0);
        rst_n = 1'b1;
        tick(2 * BIT);
        bus.rx_ready = 1'b1;
        dlv.delete();
        send_frame(8'h12, 1'b1, 1'b0);
        tick(2 * BIT);
        chk("p5_count", dlv.size(), 32'd1);
        if (dlv.size() == 1) chk("p5_byte", {24'd0, dlv[0]}, 32'h12);

`ifdef UART_RX_PARITY_EN
        // Correct then wrong even parity on the same byte.
        dlv.delete();
        f0 = ferr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        tick(2 * BIT);
        chk("p6_count", dlv.size(),    32'd1);
        if (dlv.size() == 1) chk("p6_byte", {24'd0, dlv[0]}, 32'h07);
        chk("p6_ferr",  ferr_cnt - f0, 32'd1);
`endif

        // Random traffic with a randomly stalling consumer.
        rnd_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
            rp = ($urandom_range(0, 7) == 0);
`else
            rp = 1'b0;
`endif
            send_frame(rb, rs, rp);
            if (!rs) begin
                rxd = 1'b0;
                tick($urandom_range(0, 2 * BIT));
                rxd = 1'b1;
                tick($urandom_range(BIT, 2 * BIT));
            end else begin
                tick($urandom_range(0, BIT));
            end
        end
        rnd_rdy = 1'b0;
        bus.rx_ready = 1'b1;
        tick(4 * BIT);
        chk("queue_drained", evq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive stage that sits directly downstream of `uart_core`, consuming its `txd` line. It recovers 8N1 frames at `BIT_CLK` clock cycles per bit, presents each byte on a valid/ready handshake with a one-entry holding register, and drives a `rts` flow-control output that connects straight to the transmitter's `cts`. Line errors are reported as single-cycle pulses.

## Interface
- `BIT_CLK`, 8: clock cycles per serial bit; must be even and ≥ 4; counter width is `$clog2(BIT_CLK)`.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rxd` input 1: serial line, idle high; asynchronous to `clk`.
- `rxdata` output 8: received byte; stable while `rx_valid` is high.
- `rx_valid` output 1: holding register contains an unread byte.
- `rx_ready` input 1: consumer accepts; transfer occurs on a cycle where `rx_valid && rx_ready`.
- `rts` output 1: ready-to-receive, `= !rx_valid` (registered); connect to transmitter `cts`.
- `frame_err` output 1: one-cycle pulse on stop bit sampled low (or parity mismatch, see Configuration).
- `overrun` output 1: one-cycle pulse when a good frame completes while `rx_valid` is high.

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE (PARITY added per Configuration).
- IDLE: on `rxs`==0, clear bit counter, go START.
- START: after `BIT_CLK/2` cycles (mid-bit) resample; `rxs`==0 → DATA with bit index 0; `rxs`==1 → glitch, back to IDLE, no error.
- DATA: sample every `BIT_CLK` cycles, LSB first, into shift register; after bit 7 → STOP.
- STOP: sample after `BIT_CLK` cycles. `rxs`==1: frame good → IDLE. `rxs`==0: `frame_err` pulse, byte discarded → WAIT_IDLE.
- WAIT_IDLE: stay until `rxs`==1, then IDLE (prevents break condition being read as start bits).
- Good frame, `rx_valid`==0: `rxdata` loads, `rx_valid` sets.
- Good frame, `rx_valid`==1 and `rx_ready`==0 on that cycle: `overrun` pulse, new byte dropped, old byte kept.
- Good frame on the same cycle as a handshake (`rx_valid && rx_ready`): handshake completes, new byte loads, `rx_valid` stays 1, no overrun.
- Handshake without new frame: `rx_valid` clears next edge.
- Reset mid-frame: FSM to IDLE immediately; partial byte lost; no error pulses.

## Timing
- Reset values: `rxdata`=0x00, `rx_valid`=0, `rts`=1, `frame_err`=0, `overrun`=0, FSM=IDLE.
- Synchronizer latency: 2 cycles from `rxd` edge to `rxs`.
- Stop-bit sample at `BIT_CLK/2 + 9*BIT_CLK` cycles after the `rxs` falling edge; `rx_valid`/`frame_err`/`overrun` assert on the next edge.
- Earliest next start detection: the cycle after the stop sample in IDLE (tolerates transmitter with stop bit ≥ half a bit).
- `rts` follows `rx_valid` with one cycle delay; transmitter must sample `cts` only at frame start.
- Sampling tolerance: ±(BIT_CLK/2 − 1) cycles cumulative drift over the frame.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1; PARITY state after bit 7 samples one extra bit after `BIT_CLK` cycles; mismatch with even parity of data → `frame_err` pulse, byte discarded, then normal STOP check (go WAIT_IDLE if stop low, else IDLE); stop sample moves to `BIT_CLK/2 + 10*BIT_CLK`.
- Undefined: 8N1, no PARITY state, no parity logic.

## Test plan
- BIT_CLK=8, send 0x77 then 0xAA then 0x33 with `rx_ready`=1 → `rxdata` 0x77, 0xAA, 0x33 each with one-cycle `rx_valid`, `rts` returns to 1, no error pulses.
- Send 0x55 with `rx_ready`=0, then 0xC3 → `rx_valid` held with 0x55, `rts`=0, `overrun` pulses once at 0xC3 stop; after `rx_ready`=1, 0x55 delivered, 0xC3 never appears.
- Low glitch of 3 cycles on idle `rxd` → FSM returns to IDLE, no `rx_valid`, no `frame_err`.
- Frame 0xA5 with stop bit forced low, line held low 20 bit times, then valid 0x3C → `frame_err` one pulse, no `rx_valid` for 0xA5, 0x3C received correctly.
- Assert `rst_n`=0 mid-DATA of 0xFF, release, send 0x12 → outputs at reset values during reset, only 0x12 delivered.
- With `UART_RX_PARITY_EN`: send 0x07 with parity 1 (correct) then 0x07 with parity 0 → first delivered, second gives `frame_err` and no `rx_valid`.
